// File: rtl/fetch_cycle.sv
// fetch_cycle: instruction-fetch stage.
//
// Owns the fetch PC and issues word-aligned requests to instruction memory.
// The number of requests in flight plus the entries held in the fetch queue
// is capped at FQ_DEPTH. Because of that cap the queue never overflows and
// responses never need back-pressure. In-order responses are tagged with the
// PC they belong to. They then either enter the fetch queue or go straight
// into the IF/ID register when the queue is empty. A redirect from execute
// empties the queue. It also arms a drop counter so that responses to
// requests already in flight are discarded.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   StallD       hold the IF/ID register
//   FlushD       load a bubble into the IF/ID register
//   PCSrcE       redirect request from execute
//   PCTargetE    redirect target (forced to word alignment)
//   imem_req     fetch request valid
//   imem_addr    fetch address
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  in-order response valid (always accepted)
//   imem_rdata   response instruction word
//   InstrD       instruction to decode (NOP for a bubble)
//   PCD          PC of InstrD (0 for a bubble)
//   PCPlus4D     PCD + 4 (0 for a bubble)
//   ValidD       InstrD is a real instruction
module fetch_cycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FQ_DEPTH);
    localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FQ_DEPTH - 1);
    localparam logic [31:0]   RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    // Circular-buffer pointer increment with wrap at the last entry.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    logic [31:0]   pcF_r;
    logic [31:0]   rpc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] dropCnt_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [31:0]   fqInstr_r [FQ_DEPTH];
    logic [31:0]   fqPc_r    [FQ_DEPTH];
    logic [31:0]   instrD_r;
    logic [31:0]   pcD_r;
    logic [31:0]   pcPlus4D_r;
    logic          validD_r;

    logic [CW:0]   occupancy_s;
    logic          imemReq_s;
    logic          fire_s;
    logic          dropResp_s;
    logic          accept_s;
    logic          advance_s;
    logic          pop_s;
    logic          bypass_s;
    logic          push_s;
    logic [31:0]   target_s;

    // Request gating, response classification and queue push/pop decisions.
    always_comb begin
        occupancy_s = {1'b0, outstanding_r} + {1'b0, count_r};
        imemReq_s   = rst & ~PCSrcE & (occupancy_s < DEPTH_C);
        fire_s      = imemReq_s & imem_gnt;
        // A response in the redirect cycle belongs to the old stream: never accept it.
        dropResp_s  = imem_rvalid & (dropCnt_r != ZERO_C);
        accept_s    = imem_rvalid & (dropCnt_r == ZERO_C) & ~PCSrcE;
        advance_s   = ~PCSrcE & ~FlushD & ~StallD;
        pop_s       = advance_s & (count_r != ZERO_C);
        bypass_s    = advance_s & (count_r == ZERO_C) & accept_s;
        push_s      = accept_s & ~bypass_s;
        target_s    = {PCTargetE[31:2], 2'b00};
    end

    // Fetch PC and response PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcF_r <= RESET_PC_ALIGNED;
            rpc_r <= RESET_PC_ALIGNED;
        end else if (PCSrcE) begin
            pcF_r <= target_s;
            rpc_r <= target_s;
        end else begin
            if (fire_s) begin
                pcF_r <= pcF_r + 32'd4;
            end
            if (accept_s) begin
                rpc_r <= rpc_r + 32'd4;
            end
        end
    end

    // Requests in flight (dropped ones included) and pending drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding_r <= ZERO_C;
            dropCnt_r     <= ZERO_C;
        end else begin
            case ({fire_s, imem_rvalid})
                2'b10:   outstanding_r <= outstanding_r + ONE_C;
                2'b01:   outstanding_r <= outstanding_r - ONE_C;
                default: outstanding_r <= outstanding_r;
            endcase
            if (PCSrcE) begin
                dropCnt_r <= outstanding_r - CW'(imem_rvalid);
            end else if (dropResp_s) begin
                dropCnt_r <= dropCnt_r - ONE_C;
            end
        end
    end

    // Fetch-queue occupancy and pointers.
    always_ff @(posedge clk) begin
        if (!rst || PCSrcE) begin
            count_r <= ZERO_C;
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            if (push_s) begin
                tail_r <= nextPtr(tail_r);
            end
            if (pop_s) begin
                head_r <= nextPtr(head_r);
            end
        end
    end

    // Fetch-queue storage; contents are only meaningful below count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fqInstr_r[tail_r] <= imem_rdata;
            fqPc_r[tail_r]    <= rpc_r;
        end
    end

    // IF/ID register: redirect/flush, then stall, then queue head, then bypass.
    always_ff @(posedge clk) begin
        if (!rst || PCSrcE || FlushD) begin
            instrD_r   <= NOP;
            pcD_r      <= 32'h0000_0000;
            pcPlus4D_r <= 32'h0000_0000;
            validD_r   <= 1'b0;
        end else if (StallD) begin
            instrD_r   <= instrD_r;
            pcD_r      <= pcD_r;
            pcPlus4D_r <= pcPlus4D_r;
            validD_r   <= validD_r;
        end else if (pop_s) begin
            instrD_r   <= fqInstr_r[head_r];
            pcD_r      <= fqPc_r[head_r];
            pcPlus4D_r <= fqPc_r[head_r] + 32'd4;
            validD_r   <= 1'b1;
        end else if (bypass_s) begin
            instrD_r   <= imem_rdata;
            pcD_r      <= rpc_r;
            pcPlus4D_r <= rpc_r + 32'd4;
            validD_r   <= 1'b1;
        end else begin
            instrD_r   <= NOP;
            pcD_r      <= 32'h0000_0000;
            pcPlus4D_r <= 32'h0000_0000;
            validD_r   <= 1'b0;
        end
    end

    assign imem_req  = imemReq_s;
    assign imem_addr = pcF_r;
    assign InstrD    = instrD_r;
    assign PCD       = pcD_r;
    assign PCPlus4D  = pcPlus4D_r;
    assign ValidD    = validD_r;

endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle: randomized bench for fetch_cycle.
//
// The bench contains an in-order memory stub whose instruction word is a
// function of the address. It also holds a transaction-level model of the
// fetch stage, built from plain counters and a queue of {instr, pc} entries.
// The model and the DUT are compared once per cycle. Directed phases pin the
// model with literal expectations.
module tb_fetch_cycle;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOPI  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    fetch_cycle #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH), .NOP(NOPI)) dut (
        .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    // Memory content: the instruction stored at an address.
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'hA5C3_0F10;
    endfunction

    function automatic bit rnd(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] mPcf, mRpc, mInstr, mPcd, mPcp4;
    logic        mValid;
    int          mOut, mDrop;
    logic [63:0] mFq[$];
    logic        expReq;

    // Memory stub state: addresses granted and not yet answered.
    logic [31:0] pend[$];
    logic        capReq;
    logic [31:0] capAddr;

    // Stimulus knobs.
    bit          manual;
    logic        vRst, vStall, vFlush, vJump, vGnt;
    logic [31:0] vTarget;
    int          pG, pR, pS, pF, pJ, pRst;

    task automatic bubble();
        mInstr = NOPI; mPcd = 32'h0; mPcp4 = 32'h0; mValid = 1'b0;
    endtask

    task automatic load(input logic [63:0] e);
        mInstr = e[63:32]; mPcd = e[31:0]; mPcp4 = e[31:0] + 32'd4; mValid = 1'b1;
    endtask

    task automatic modelUpdate();
        logic        acc;
        logic [63:0] ent;
        acc = 1'b0;
        ent = 64'h0;
        if (!rst) begin
            mPcf = 32'h0; mRpc = 32'h0; mOut = 0; mDrop = 0;
            mFq.delete();
            bubble();
        end else if (PCSrcE) begin
            mDrop = mOut - int'(imem_rvalid);
            mOut  = mOut - int'(imem_rvalid);
            mFq.delete();
            mPcf = {PCTargetE[31:2], 2'b00};
            mRpc = mPcf;
            bubble();
        end else begin
            if (imem_rvalid) begin
                mOut--;
                if (mDrop > 0) begin
                    mDrop--;
                end else begin
                    acc  = 1'b1;
                    ent  = {imem_rdata, mRpc};
                    mRpc = mRpc + 32'd4;
                end
            end
            if (expReq && imem_gnt) begin
                mOut++;
                mPcf = mPcf + 32'd4;
            end
            if (FlushD) begin
                bubble();
            end else if (StallD) begin
                mValid = mValid;
            end else if (mFq.size() > 0) begin
                load(mFq.pop_front());
            end else if (acc) begin
                load(ent);
                acc = 1'b0;
            end else begin
                bubble();
            end
            if (acc) mFq.push_back(ent);
        end
    endtask

    task automatic memUpdate();
        if (!rst) begin
            pend.delete();
        end else begin
            if (imem_rvalid) void'(pend.pop_front());
            if (capReq && imem_gnt) pend.push_back(capAddr);
        end
    endtask

    // One clock: advance model and memory on the edge, drive on the falling
    // edge, then compare everything against the model.
    task automatic step();
        @(posedge clk);
        modelUpdate();
        memUpdate();
        @(negedge clk);
        if (manual) begin
            rst = vRst; StallD = vStall; FlushD = vFlush; PCSrcE = vJump;
            PCTargetE = vTarget; imem_gnt = vGnt;
        end else begin
            rst       = ($urandom_range(0, 999) < pRst) ? 1'b0 : 1'b1;
            StallD    = rnd(pS);
            FlushD    = rnd(pF);
            PCSrcE    = rnd(pJ);
            PCTargetE = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            imem_gnt  = rnd(pG);
        end
        if (rst && pend.size() > 0 && rnd(pR)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instrOf(pend[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        expReq = rst && !PCSrcE && ((mOut + mFq.size()) < DEPTH);
        check("imem_req", {31'h0, imem_req}, {31'h0, expReq});
        if (expReq) check("imem_addr", imem_addr, mPcf);
        check("InstrD", InstrD, mInstr);
        check("PCD", PCD, mPcd);
        check("PCPlus4D", PCPlus4D, mPcp4);
        check("ValidD", {31'h0, ValidD}, {31'h0, mValid});
        if (ValidD) check("instr_matches_pc", InstrD, instrOf(PCD));
        capReq  = imem_req;
        capAddr = imem_addr;
    endtask

    // Step until ValidD rises; check its PCD against a literal target.
    task automatic expectFirstValid(input string name, input logic [31:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (ValidD) begin
                found = 1'b1;
                check(name, PCD, pc);
            end
        end
        if (!found) check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    logic [31:0] held;
    bit          seenReq;

    initial begin
        rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        capReq = 1'b0; capAddr = 32'h0; expReq = 1'b0;
        manual = 1'b1;
        vRst = 1'b0; vStall = 1'b0; vFlush = 1'b0; vJump = 1'b0; vGnt = 1'b0; vTarget = 32'h0;
        pR = 100;

        // Reset state.
        repeat (3) step();
        check("rst_InstrD", InstrD, 32'h0000_0013);
        check("rst_ValidD", {31'h0, ValidD}, 32'h0);
        check("rst_PCD", PCD, 32'h0);
        check("rst_PCPlus4D", PCPlus4D, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);

        // Zero-latency stream from address 0.
        vRst = 1'b1; vGnt = 1'b1;
        step();
        check("stream_addr0", imem_addr, 32'h0);
        check("stream_req0", {31'h0, imem_req}, 32'h1);
        step();
        check("stream_addr1", imem_addr, 32'h4);
        step();
        check("stream_first_valid", {31'h0, ValidD}, 32'h1);
        check("stream_first_pcd", PCD, 32'h0);
        check("stream_first_instr", InstrD, 32'hA5C3_0F10);
        check("stream_first_pcp4", PCPlus4D, 32'h4);
        step();
        check("stream_second_pcd", PCD, 32'h4);
        repeat (6) step();

        // Stall throttle.
        vStall = 1'b1;
        step(); step();
        held = PCD;
        repeat (3) step();
        check("stall_hold_pcd", PCD, held);
        check("stall_req_low", {31'h0, imem_req}, 32'h0);
        vStall = 1'b0;
        repeat (6) step();

        // Redirect with two requests in flight.
        pR = 0;
        repeat (3) step();
        vJump = 1'b1; vTarget = 32'h0000_0100;
        step();
        vJump = 1'b0; pR = 100;
        seenReq = 1'b0;
        for (int i = 0; i < 20 && !seenReq; i++) begin
            step();
            if (imem_req) begin
                seenReq = 1'b1;
                check("redir_first_addr", imem_addr, 32'h0000_0100);
            end
        end
        if (!seenReq) check("redir_req_timeout", 32'h0, 32'h1);
        expectFirstValid("redir_first_pcd", 32'h0000_0100);

        // Redirect coincident with a response, unaligned target.
        repeat (4) step();
        vJump = 1'b1; vTarget = 32'h0000_0203;
        step();
        vJump = 1'b0;
        expectFirstValid("redir2_first_pcd", 32'h0000_0200);

        // Flush during stall keeps the queue.
        repeat (4) step();
        vStall = 1'b1;
        step(); step();
        held = PCD;
        vFlush = 1'b1;
        step();
        vFlush = 1'b0; vStall = 1'b0;
        step();
        check("flush_instr", InstrD, 32'h0000_0013);
        check("flush_valid", {31'h0, ValidD}, 32'h0);
        expectFirstValid("flush_resume_pcd", held + 32'd4);

        // Reset mid-operation with a full queue.
        vStall = 1'b1;
        repeat (4) step();
        vRst = 1'b0;
        step(); step();
        check("midrst_InstrD", InstrD, 32'h0000_0013);
        check("midrst_ValidD", {31'h0, ValidD}, 32'h0);
        check("midrst_PCD", PCD, 32'h0);
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        vRst = 1'b1; vStall = 1'b0;
        step();
        check("midrst_restart_req", {31'h0, imem_req}, 32'h1);
        check("midrst_restart_addr", imem_addr, 32'h0);

        // Randomized operation under several traffic mixes.
        manual = 1'b0;
        for (int r = 0; r < 4; r++) begin
            case (r)
                0:       begin pG = 90;  pR = 90;  pS = 10; pF = 5;  pJ = 3;  pRst = 2; end
                1:       begin pG = 50;  pR = 40;  pS = 30; pF = 10; pJ = 8;  pRst = 3; end
                2:       begin pG = 100; pR = 100; pS = 0;  pF = 0;  pJ = 10; pRst = 0; end
                default: begin pG = 30;  pR = 70;  pS = 50; pF = 20; pJ = 15; pRst = 5; end
            endcase
            repeat (1000) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
